// File: rtl/line_clear_pkg.sv
// Shared definitions for the line-clear engine.
//   - Default board geometry and lifetime counter width.
//   - Width derivations for the row index and the per-pass cleared-line count.
//   - FSM state encoding.
//   - row_base(): bit offset of a row inside the flattened board vector.
package line_clear_pkg;

   localparam int unsigned WIDTH_DEF   = 10;
   localparam int unsigned HEIGHT_DEF  = 20;
   localparam int unsigned TOTAL_W_DEF = 16;

   typedef enum logic [1:0] {
      StIdle,
      StScan,
      StFinish
   } state_e;

   // Bits needed to index any row 0..height-1.
   function automatic int unsigned row_w(input int unsigned height);
      return $clog2(height);
   endfunction

   // Bits needed to count 0..height cleared rows.
   function automatic int unsigned cnt_w(input int unsigned height);
      return $clog2(height + 1);
   endfunction

   // Row r occupies bits [r*width +: width]; row 0 is the bottom row.
   function automatic int unsigned row_base(input int unsigned row, input int unsigned width);
      return row * width;
   endfunction

endpackage

// File: rtl/line_clear_engine_row_shifter.sv
// row_shifter: combinational collapse of one board row.
// Ports:
//   board     - flattened board, row r at bits [r*WIDTH +: WIDTH]
//   row       - index of the row being removed
//   collapsed - board with that row removed: rows below pass through, every row
//               at or above the index takes the row above it, top row is zero
module row_shifter
   import line_clear_pkg::*;
#(
   parameter int unsigned WIDTH  = WIDTH_DEF,
   parameter int unsigned HEIGHT = HEIGHT_DEF,
   parameter int unsigned ROW_W  = row_w(HEIGHT)
) (
   input  logic [WIDTH*HEIGHT-1:0] board,
   input  logic [ROW_W-1:0]        row,
   output logic [WIDTH*HEIGHT-1:0] collapsed
);

   genvar k;
   generate
      for (k = 0; k < HEIGHT; k++) begin : g_row
         if (k == HEIGHT - 1) begin : g_top
            assign collapsed[row_base(k, WIDTH) +: WIDTH] = '0;
         end else begin : g_body
            assign collapsed[row_base(k, WIDTH) +: WIDTH] =
               (row <= ROW_W'(k)) ? board[row_base(k + 1, WIDTH) +: WIDTH]
                                  : board[row_base(k, WIDTH) +: WIDTH];
         end
      end
   endgenerate

endmodule

// File: rtl/line_clear_engine.sv
// line_clear_engine: removes every complete row from a board snapshot.
// Ports:
//   clk, reset     - clock and synchronous active-high reset
//   start          - accepted only while idle; latches board_in
//   board_in       - board snapshot, row r at bits [r*WIDTH +: WIDTH], row 0 at bottom
//   busy           - high from the cycle after acceptance until done
//   done           - one-cycle pulse; board_out/lines_cleared valid from here
//   board_out      - compacted board, held until the next pass finishes
//   lines_cleared  - rows removed in the last pass
//   lines_total    - saturating lifetime sum of lines_cleared
// One row is examined per cycle. A full row is collapsed in place and the same
// index is rechecked, so a pass takes HEIGHT + cleared scan cycles.
module line_clear_engine
   import line_clear_pkg::*;
#(
   parameter int unsigned WIDTH   = WIDTH_DEF,
   parameter int unsigned HEIGHT  = HEIGHT_DEF,
   parameter int unsigned ROW_W   = row_w(HEIGHT),
   parameter int unsigned CNT_W   = cnt_w(HEIGHT),
   parameter int unsigned TOTAL_W = TOTAL_W_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [WIDTH*HEIGHT-1:0] board_in,
   output logic                    busy,
   output logic                    done,
   output logic [WIDTH*HEIGHT-1:0] board_out,
   output logic [CNT_W-1:0]        lines_cleared,
   output logic [TOTAL_W-1:0]      lines_total
);

   state_e state_q, state_d;

   logic [WIDTH*HEIGHT-1:0] work_q, work_d;
   logic [ROW_W-1:0]        row_q, row_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [WIDTH*HEIGHT-1:0] board_out_q, board_out_d;
   logic [CNT_W-1:0]        lines_cleared_q, lines_cleared_d;
   logic [TOTAL_W-1:0]      lines_total_q, lines_total_d;

   logic [HEIGHT-1:0][WIDTH-1:0] work_rows;
   logic [WIDTH*HEIGHT-1:0]      shifted;
   logic                         row_full;
   logic                         last_row;
   logic [TOTAL_W:0]             total_sum;

   assign work_rows = work_q;
   assign row_full  = &work_rows[row_q];
   assign last_row  = (row_q == ROW_W'(HEIGHT - 1));
   // One extra bit catches the carry that signals saturation.
   assign total_sum = {1'b0, lines_total_q} + (TOTAL_W + 1)'(cnt_q);

   row_shifter #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .ROW_W  (ROW_W)
   ) u_row_shifter (
      .board     (work_q),
      .row       (row_q),
      .collapsed (shifted)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (start) state_d = StScan;
         StScan:   if (!row_full && last_row) state_d = StFinish;
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Datapath and output next values.
   always_comb begin
      work_d          = work_q;
      row_d           = row_q;
      cnt_d           = cnt_q;
      busy_d          = busy_q;
      done_d          = 1'b0;
      board_out_d     = board_out_q;
      lines_cleared_d = lines_cleared_q;
      lines_total_d   = lines_total_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               work_d = board_in;
               row_d  = '0;
               cnt_d  = '0;
               busy_d = 1'b1;
            end
         end
         StScan: begin
            if (row_full) begin
               // Keep row_q so the row that dropped into this slot is tested next.
               work_d = shifted;
               cnt_d  = cnt_q + CNT_W'(1);
            end else if (!last_row) begin
               row_d = row_q + ROW_W'(1);
            end
         end
         StFinish: begin
            board_out_d     = work_q;
            lines_cleared_d = cnt_q;
            done_d          = 1'b1;
            busy_d          = 1'b0;
            lines_total_d   = total_sum[TOTAL_W] ? '1 : total_sum[TOTAL_W-1:0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         work_q          <= '0;
         row_q           <= '0;
         cnt_q           <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         board_out_q     <= '0;
         lines_cleared_q <= '0;
         lines_total_q   <= '0;
      end else begin
         work_q          <= work_d;
         row_q           <= row_d;
         cnt_q           <= cnt_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         board_out_q     <= board_out_d;
         lines_cleared_q <= lines_cleared_d;
         lines_total_q   <= lines_total_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign board_out     = board_out_q;
   assign lines_cleared = lines_cleared_q;
   assign lines_total   = lines_total_q;

endmodule
